load_scoreboard_hazard_unit: RTL
================================

Name: load_scoreboard_hazard_unit

Overview:
- Next-generation load-use hazard unit for the RV32I pipeline, supporting multi-cycle and variable-latency data memory.
- Tracks up to DEPTH issued, unretired loads in an in-order tag FIFO.
- Stalls decode while any source register matches the load in EX or any outstanding load.
- Back-pressures EX when the FIFO is full, and keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- DEPTH, 2, maximum outstanding loads (power of 2, ≥1).
- CNT_W, 16, width of stall-cycle counter.
- RSP_BYPASS, 1, 1 = a load retiring this cycle no longer causes a hazard (WB forwarding exists); 0 = it still stalls this cycle.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_d  in  32  IF/ID instruction word; rs1=[19:15], rs2=[24:20]
- use_rs1_d  in  1  decode instruction reads rs1
- use_rs2_d  in  1  decode instruction reads rs2
- load_e  in  1  valid load in EX this cycle
- rd_e  in  5  EX destination register
- kill_e  in  1  EX instruction squashed (branch flush); load is not enqueued
- mem_rsp_valid  in  1  oldest outstanding load returns data this cycle
- stall_f  out  1  hold PC/IF
- pc_write  out  1  ~stall_f
- stall_d  out  1  hold IF/ID
- flush_e  out  1  insert bubble into ID/EX
- stall_e  out  1  hold EX (FIFO full)
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy
- stall_cycles  out  CNT_W  saturating count of cycles with stall_d=1
- rsp_err  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and occupancy cleared, all entries invalid.
  - stall_cycles=0, rsp_err=0.
  - Combinational outputs follow from the empty state: stall_*=0, flush_e=0, pc_write=1.
- Enqueue: load_e & ~kill_e & ~stall_e pushes rd_e at the tail on the rising edge. rd_e=0 is still enqueued to keep response ordering, but never matches for hazards.
- Dequeue: mem_rsp_valid pops the head.
  - Responses are strictly in order.
  - mem_rsp_valid with occupancy 0: no pop, rsp_err set (sticky until reset).
- Full:
  - stall_e = load_e & ~kill_e & full & ~mem_rsp_valid.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
- Hazard sources, with match(r) = r≠0 & ((use_rs1_d & r==rs1) | (use_rs2_d & r==rs2)):
  - EX hazard: load_e & ~kill_e & match(rd_e).
  - Pending hazard: any valid entry i with match(tag[i]). If RSP_BYPASS=1, the head entry is excluded while mem_rsp_valid=1.
  - hazard = EX hazard | pending hazard | stall_e.
- Outputs (all combinational, no added latency):
  - stall_f = stall_d = hazard, pc_write = ~hazard.
  - flush_e = hazard & ~stall_e. When stall_e=1, the EX load is held in place rather than bubbled.
- Stall duration: for a single load with response latency L cycles after enqueue, a dependent decode instruction stalls 1 (EX cycle) + L-1 cycles with RSP_BYPASS=1, and +L with RSP_BYPASS=0.
- stall_cycles increments on every clock with stall_d=1 and saturates at all-ones.
- Occupancy arithmetic: next = occ + push - pop, pop only if occ>0. Pointers wrap modulo DEPTH.
- kill_e with load_e: no enqueue and no EX hazard. Already-enqueued loads are never cancelled.

Decomposition:
- Shared package: REG_AW=5, RS1/RS2 bit-field constants, and the match function (also used by the forwarding unit).
- One sub-module: load_tag_fifo (DEPTH-entry tag FIFO). It exposes per-entry valid and tag vectors plus head index, full, empty and count.
- Hazard compare and stall logic sit in the top module.

Test Plan:
- No loads, any instr_d → stall_f=0, pc_write=1, flush_e=0, outstanding=0 every cycle.
- Load x5 in EX, decode add x6,x5,x1 (use_rs1_d=1); response 3 cycles after enqueue, RSP_BYPASS=1 → stall_d high exactly 3 cycles, flush_e high same 3 cycles, stall_cycles=3.
- Same stimulus with use_rs1_d=0, or with the load to x0 → no stall, stall_cycles stays 0.
- DEPTH=2: two loads enqueued with no response, third load in EX → stall_e=1, flush_e=0, occupancy 2. Assert mem_rsp_valid → stall_e drops that cycle; next cycle occupancy stays 2 and the third load's tag is at the tail.
- load_e with kill_e=1, rd_e=7, decode reads x7 → no stall, outstanding unchanged.
- mem_rsp_valid with FIFO empty → rsp_err=1 and held. rst_n pulsed low mid-stall with 2 outstanding → all outputs return to reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/load_scoreboard_hazard_unit_pkg.sv
// Shared register-field definitions and the source/destination match rule.
// Latency: n/a (package). Backpressure: n/a.
// Contents: REG_AW, rs1/rs2 bit positions in the instruction word, reg_match().
package load_scoreboard_hazard_unit_pkg;

   localparam int REG_AW  = 5;
   localparam int RS1_LSB = 15;   // rs1 = instr[19:15]
   localparam int RS2_LSB = 20;   // rs2 = instr[24:20]

   // True when a producer register r is read by the decode instruction.
   // x0 is hard-wired zero, so it never creates a dependency.
   function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] rs1,
                                      input logic [REG_AW-1:0] rs2,
                                      input logic              use_rs1,
                                      input logic              use_rs2);
      return (r != '0) && ((use_rs1 && (r == rs1)) || (use_rs2 && (r == rs2)));
   endfunction

endpackage

// File: rtl/load_tag_fifo.sv
// In-order FIFO of destination tags for issued, unretired loads.
// Latency: push/pop take effect on the next rising edge; all outputs are registered state.
// Backpressure: push is ignored when full unless a pop happens the same cycle; pop on empty is ignored.
// Ports: clk, rst_n, push/push_tag, pop in; entry_vld/entry_tag per entry, head_idx, full, empty, count out.
module load_tag_fifo
   import load_scoreboard_hazard_unit_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OCC_W = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [REG_AW-1:0]              push_tag,
   input  logic                           pop,
   output logic [DEPTH-1:0]               entry_vld,
   output logic [DEPTH-1:0][REG_AW-1:0]   entry_tag,
   output logic [IDX_W-1:0]               head_idx,
   output logic                           full,
   output logic                           empty,
   output logic [OCC_W-1:0]               count
);

   logic [IDX_W-1:0] tail_idx;
   logic             pop_eff;
   logic             push_eff;

   // Explicit wrap keeps DEPTH=1 correct where the index is wider than needed.
   function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == OCC_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_eff  = pop & ~empty;
   assign push_eff = push & (~full | pop_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_idx  <= '0;
         tail_idx  <= '0;
         count     <= '0;
         entry_vld <= '0;
         entry_tag <= '0;
      end else begin
         if (pop_eff) begin
            entry_vld[head_idx] <= 1'b0;
            head_idx            <= ptr_next(head_idx);
         end
         // Ordered after the pop: when full, head==tail and the new entry must stay valid.
         if (push_eff) begin
            entry_vld[tail_idx] <= 1'b1;
            entry_tag[tail_idx] <= push_tag;
            tail_idx            <= ptr_next(tail_idx);
         end
         count <= count + OCC_W'(push_eff) - OCC_W'(pop_eff);
      end
   end

endmodule

// File: rtl/load_scoreboard_hazard_unit.sv
// Load-use hazard unit: stalls decode on dependencies against the EX load and all outstanding loads.
// Latency: all stall/flush outputs are combinational from inputs and FIFO state; counters update on the edge.
// Backpressure: stall_e holds a load in EX while the tag FIFO is full and no response frees a slot.
// Ports: instr_d/use_rs*_d (decode), load_e/rd_e/kill_e (EX), mem_rsp_valid (WB) in;
//        stall_f, pc_write, stall_d, flush_e, stall_e, outstanding, stall_cycles, rsp_err out.
module load_scoreboard_hazard_unit
   import load_scoreboard_hazard_unit_pkg::*;
#(
   parameter  int DEPTH      = 2,
   parameter  int CNT_W      = 16,
   parameter  int RSP_BYPASS = 1,
   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OCC_W      = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic              load_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              kill_e,
   input  logic              mem_rsp_valid,
   output logic              stall_f,
   output logic              pc_write,
   output logic              stall_d,
   output logic              flush_e,
   output logic              stall_e,
   output logic [OCC_W-1:0]  outstanding,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic              rsp_err
);

   logic [REG_AW-1:0]             rs1_d;
   logic [REG_AW-1:0]             rs2_d;
   logic                          load_live;
   logic                          push;
   logic [DEPTH-1:0]              entry_vld;
   logic [DEPTH-1:0][REG_AW-1:0]  entry_tag;
   logic [IDX_W-1:0]              head_idx;
   logic                          full;
   logic                          empty;
   logic                          ex_haz;
   logic                          pend_haz;
   logic                          hazard;
   logic                          unused_instr_bits;

   assign rs1_d             = instr_d[RS1_LSB +: REG_AW];
   assign rs2_d             = instr_d[RS2_LSB +: REG_AW];
   assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:0]};

   // A squashed load neither enqueues nor creates a hazard.
   assign load_live = load_e & ~kill_e;
   // A response in the same cycle frees the head slot, so a full FIFO can still accept.
   assign stall_e   = load_live & full & ~mem_rsp_valid;
   assign push      = load_live & ~stall_e;

   load_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_tag  (rd_e),
      .pop       (mem_rsp_valid),
      .entry_vld (entry_vld),
      .entry_tag (entry_tag),
      .head_idx  (head_idx),
      .full      (full),
      .empty     (empty),
      .count     (outstanding)
   );

   assign ex_haz = load_live & reg_match(rd_e, rs1_d, rs2_d, use_rs1_d, use_rs2_d);

   // With WB forwarding, the load returning this cycle can feed decode directly.
   always_comb begin
      pend_haz = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i] && reg_match(entry_tag[i], rs1_d, rs2_d, use_rs1_d, use_rs2_d) &&
             !((RSP_BYPASS != 0) && mem_rsp_valid && (head_idx == IDX_W'(i)))) begin
            pend_haz = 1'b1;
         end
      end
   end

   assign hazard   = ex_haz | pend_haz | stall_e;
   assign stall_f  = hazard;
   assign stall_d  = hazard;
   assign pc_write = ~hazard;
   // A held EX load must not be replaced by a bubble.
   assign flush_e  = hazard & ~stall_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         rsp_err      <= 1'b0;
      end else begin
         if (stall_d && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (mem_rsp_valid && empty) begin
            rsp_err <= 1'b1;
         end
      end
   end

endmodule
